// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and state type for the LSU bus front-end
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AWW,
        ST_B,
        ST_RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - byte-lane steering, strobes, load extension and misalign detect
module lsu_data_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_rdata,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [3:0]  strb_base;
    logic [31:0] lane;

    always_comb begin
        strb_base = 4'b0000;
        case (size)
            SIZE_B:  strb_base = 4'b0001;
            SIZE_H:  strb_base = 4'b0011;
            SIZE_W:  strb_base = 4'b1111;
            default: strb_base = 4'b0000;
        endcase
    end

    // Shifts past the top lane simply fall off; the bus never sees a wrapped strobe.
    assign bus_wstrb = strb_base << off;
    assign bus_wdata = store_data << {off, 3'b000};
    assign lane      = bus_rdata >> {off, 3'b000};

    always_comb begin
        load_data = lane;
        case (size)
            SIZE_B:  load_data = {{24{~is_unsigned & lane[7]}}, lane[7:0]};
            SIZE_H:  load_data = {{16{~is_unsigned & lane[15]}}, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    assign misaligned = ((size == SIZE_H) && off[0]) ||
                        ((size == SIZE_W) && (off != 2'b00));

endmodule

// File: rtl/lsu_axi_master.sv
// rtl/lsu_axi_master.sv - single-outstanding load/store front-end onto an AXI4-Lite port
module lsu_axi_master
    import lsu_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    output logic        bready,
    input  logic [1:0]  bresp,
    input  logic        bvalid
);

    lsu_state_t  state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;

    logic [31:0] araddr_d, awaddr_d, wdata_d, resp_rdata_d;
    logic [3:0]  wstrb_d;
    logic        arvalid_d, awvalid_d, wvalid_d, rready_d, bready_d;
    logic        resp_valid_d, resp_err_d;

    logic        idle;
    logic [1:0]  al_off, al_size;
    logic        al_uns;
    logic [31:0] al_wdata, al_load;
    logic [3:0]  al_wstrb;
    logic        al_misaligned;
    logic        req_illegal;
    logic        aw_pending, w_pending;

    assign idle      = (state_q == ST_IDLE);
    assign req_ready = idle;

    // While idle the aligner looks at the incoming request; afterwards at the latched one.
    assign al_off  = idle ? req_addr[1:0] : off_q;
    assign al_size = idle ? req_size      : size_q;
    assign al_uns  = idle ? req_unsigned  : uns_q;

    lsu_data_align u_align (
        .off         (al_off),
        .size        (al_size),
        .is_unsigned (al_uns),
        .store_data  (req_wdata),
        .bus_rdata   (rdata),
        .bus_wdata   (al_wdata),
        .bus_wstrb   (al_wstrb),
        .load_data   (al_load),
        .misaligned  (al_misaligned)
    );

    assign req_illegal = (req_size == 2'd3) || (ALIGN_CHECK && al_misaligned);

    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        araddr_d     = araddr;
        arvalid_d    = arvalid;
        rready_d     = rready;
        awaddr_d     = awaddr;
        awvalid_d    = awvalid;
        wdata_d      = wdata;
        wstrb_d      = wstrb;
        wvalid_d     = wvalid;
        bready_d     = bready;
        resp_valid_d = resp_valid;
        resp_rdata_d = resp_rdata;
        resp_err_d   = resp_err;
        aw_pending   = awvalid && !awready;
        w_pending    = wvalid && !wready;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    off_d  = req_addr[1:0];
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    if (req_illegal) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else if (req_wen) begin
                        state_d   = ST_AWW;
                        awaddr_d  = req_addr;
                        awvalid_d = 1'b1;
                        wdata_d   = al_wdata;
                        wstrb_d   = al_wstrb;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_AR;
                        araddr_d  = req_addr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_AR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_R;
                end
            end
            ST_R: begin
                if (rvalid) begin
                    rready_d     = 1'b0;
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = (rresp != AXI_RESP_OKAY);
                    resp_rdata_d = (rresp != AXI_RESP_OKAY) ? 32'h0 : al_load;
                end
            end
            ST_AWW: begin
                // Address and data handshakes finish independently, possibly in the same cycle.
                awvalid_d = aw_pending;
                wvalid_d  = w_pending;
                if (!aw_pending && !w_pending) begin
                    bready_d = 1'b1;
                    state_d  = ST_B;
                end
            end
            ST_B: begin
                if (bvalid) begin
                    bready_d     = 1'b0;
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = (bresp != AXI_RESP_OKAY);
                    resp_rdata_d = 32'h0;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            off_q      <= 2'b00;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            araddr     <= 32'h0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awaddr     <= 32'h0;
            awvalid    <= 1'b0;
            wdata      <= 32'h0;
            wstrb      <= 4'b0000;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            araddr     <= araddr_d;
            arvalid    <= arvalid_d;
            rready     <= rready_d;
            awaddr     <= awaddr_d;
            awvalid    <= awvalid_d;
            wdata      <= wdata_d;
            wstrb      <= wstrb_d;
            wvalid     <= wvalid_d;
            bready     <= bready_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_err   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_lsu_axi_master.sv
// tb/tb_lsu_axi_master.sv - directed self-checking bench for lsu_axi_master
module tb_lsu_axi_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rready, rvalid;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, bready, bvalid;
    logic [3:0]  wstrb;

    int n_cmp = 0;
    int n_bad = 0;

    lsu_axi_master #(.ALIGN_CHECK(1'b1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rready(rready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bready(bready), .bresp(bresp), .bvalid(bvalid)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] size, input logic uns);
        req_wen = wen; req_addr = addr; req_wdata = wd; req_size = size;
        req_unsigned = uns; req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] rd, input logic [1:0] rr,
                           input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
        int t;
        chk({tag, ":req_ready"}, req_ready, 1'b1);
        issue(1'b0, addr, 32'h0, size, uns);
        t = 1;
        while (!arvalid && t < 20) begin @(negedge clock); t++; end
        chk({tag, ":arvalid"}, arvalid, 1'b1);
        chk({tag, ":araddr"}, araddr, addr);
        arready = 1'b1;
        @(negedge clock); t++;
        arready = 1'b0;
        chk({tag, ":arvalid_drop"}, arvalid, 1'b0);
        while (!rready && t < 20) begin @(negedge clock); t++; end
        rdata = rd; rresp = rr; rvalid = 1'b1;
        @(negedge clock); t++;
        rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        while (!resp_valid && t < 30) begin @(negedge clock); t++; end
        chk({tag, ":resp_valid"}, resp_valid, 1'b1);
        if (exp_lat > 0) chk({tag, ":latency"}, t, exp_lat);
        chk({tag, ":rdata"}, resp_rdata, exp_data);
        chk({tag, ":err"}, resp_err, exp_err);
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        chk({tag, ":resp_done"}, {resp_valid, req_ready}, 2'b01);
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [1:0] size, input int aw_dly, input int w_dly,
                            input logic [1:0] br, input logic [31:0] exp_wdata,
                            input logic [3:0] exp_wstrb, input logic exp_err, input int hold);
        int  last;
        int  t;
        logic proto_bad;
        issue(1'b1, addr, wd, size, 1'b0);
        chk({tag, ":aw_w_valid"}, {awvalid, wvalid}, 2'b11);
        chk({tag, ":awaddr"}, awaddr, addr);
        chk({tag, ":wdata"}, wdata, exp_wdata);
        chk({tag, ":wstrb"}, wstrb, exp_wstrb);
        last = (aw_dly > w_dly) ? aw_dly : w_dly;
        proto_bad = 1'b0;
        for (int k = 0; k <= last; k++) begin
            if (awvalid !== (k <= aw_dly) || wvalid !== (k <= w_dly) || bready !== 1'b0)
                proto_bad = 1'b1;
            if (awaddr !== addr || wdata !== exp_wdata || wstrb !== exp_wstrb)
                proto_bad = 1'b1;
            awready = (k == aw_dly);
            wready  = (k == w_dly);
            @(negedge clock);
        end
        awready = 1'b0; wready = 1'b0;
        chk({tag, ":handshake_protocol"}, proto_bad, 1'b0);
        chk({tag, ":in_B"}, {awvalid, wvalid, bready}, 3'b001);
        bresp = br; bvalid = 1'b1;
        @(negedge clock);
        bvalid = 1'b0; bresp = 2'b00;
        chk({tag, ":resp_valid"}, resp_valid, 1'b1);
        chk({tag, ":err"}, resp_err, exp_err);
        chk({tag, ":rdata"}, resp_rdata, 32'h0);
        proto_bad = 1'b0;
        for (t = 0; t < hold; t++) begin
            @(negedge clock);
            if (resp_valid !== 1'b1 || resp_err !== exp_err || resp_rdata !== 32'h0 || req_ready !== 1'b0)
                proto_bad = 1'b1;
        end
        if (hold > 0) chk({tag, ":resp_hold"}, proto_bad, 1'b0);
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        chk({tag, ":resp_done"}, {resp_valid, req_ready}, 2'b01);
    endtask

    task automatic do_illegal(input string tag, input logic wen, input logic [31:0] addr,
                              input logic [1:0] size);
        int   t;
        logic bus_seen;
        issue(wen, addr, 32'hFFFF_FFFF, size, 1'b0);
        t = 1;
        bus_seen = arvalid | awvalid | wvalid;
        while (!resp_valid && t < 20) begin
            @(negedge clock); t++;
            bus_seen = bus_seen | arvalid | awvalid | wvalid;
        end
        chk({tag, ":resp_valid"}, resp_valid, 1'b1);
        chk({tag, ":err_data"}, {resp_err, resp_rdata}, {1'b1, 32'h0});
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        bus_seen = bus_seen | arvalid | awvalid | wvalid;
        chk({tag, ":no_bus"}, bus_seen, 1'b0);
        chk({tag, ":resp_done"}, {resp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        int   t;
        logic rv_seen;
        reset = 1'b1;
        req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_unsigned = 0;
        resp_ready = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        chk("reset:valids", {arvalid, awvalid, wvalid, rready, bready, resp_valid}, 6'b0);
        chk("reset:resp", {resp_err, resp_rdata}, 33'h0);
        chk("reset:regs", araddr | awaddr | wdata | {28'h0, wstrb}, 32'h0);
        chk("reset:req_ready", req_ready, 1'b1);

        do_load("lw",     32'h8000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0, 3);
        do_load("lb",     32'h8000_0003, 2'd0, 1'b0, 32'h8012_3456, 2'b00, 32'hFFFF_FF80, 1'b0, 0);
        do_load("lbu",    32'h8000_0003, 2'd0, 1'b1, 32'h8012_3456, 2'b00, 32'h0000_0080, 1'b0, 0);
        do_load("lh",     32'h8000_0002, 2'd1, 1'b0, 32'h8001_7777, 2'b00, 32'hFFFF_8001, 1'b0, 0);
        do_load("lhu",    32'h8000_0000, 2'd1, 1'b1, 32'h1234_F00D, 2'b00, 32'h0000_F00D, 1'b0, 0);
        do_load("lb1",    32'h8000_0001, 2'd0, 1'b0, 32'h1234_5678, 2'b00, 32'h0000_0056, 1'b0, 0);
        do_load("lw_dec", 32'h8000_0008, 2'd2, 1'b0, 32'h5555_5555, 2'b11, 32'h0000_0000, 1'b1, 0);

        do_store("sh",     32'h8000_0002, 32'h0000_1234, 2'd1, 0, 3, 2'b00, 32'h1234_0000, 4'b1100, 1'b0, 0);
        do_store("sb",     32'h8000_0001, 32'h0000_00A5, 2'd0, 2, 0, 2'b00, 32'h0000_A500, 4'b0010, 1'b0, 0);
        do_store("sw",     32'h8000_000C, 32'hCAFE_F00D, 2'd2, 0, 0, 2'b00, 32'hCAFE_F00D, 4'b1111, 1'b0, 0);
        do_store("sw_err", 32'h8000_0010, 32'h0BAD_0BAD, 2'd2, 1, 1, 2'b10, 32'h0BAD_0BAD, 4'b1111, 1'b1, 5);

        do_illegal("lw_mis", 1'b0, 32'h8000_0002, 2'd2);
        do_illegal("sh_mis", 1'b1, 32'h8000_0003, 2'd1);
        do_illegal("size3",  1'b0, 32'h8000_0000, 2'd3);

        // Reset while the read address is stalled.
        issue(1'b0, 32'h8000_0020, 32'h0, 2'd2, 1'b0);
        chk("rst_mid:arvalid_before", arvalid, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid:arvalid_after", {arvalid, rready, resp_valid}, 3'b000);
        reset = 1'b0;
        rv_seen = 1'b0;
        for (t = 0; t < 5; t++) begin
            @(negedge clock);
            rv_seen = rv_seen | resp_valid | arvalid;
        end
        chk("rst_mid:quiet", rv_seen, 1'b0);
        do_load("rst_next", 32'h8000_0024, 2'd2, 1'b0, 32'h0123_4567, 2'b00, 32'h0123_4567, 1'b0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
